// File: rtl/tile_writeback_if.sv
// Framebuffer write-port beat bundle: one address/data beat per pixel,
// moved with a valid/ready handshake.
interface tile_writeback_if #(
    parameter int ADDR_W = 20
);
    logic              pixValid;
    logic [ADDR_W-1:0] pixAddr;
    logic [15:0]       pixData;
    logic              pixReady;

    modport master (output pixValid, pixAddr, pixData, input pixReady);
    modport slave  (input pixValid, pixAddr, pixData, output pixReady);
endinterface

// File: rtl/tile_writeback.sv
// Streams one DIM x DIM RGB565 nanotile from the idle ping-pong buffer to the
// framebuffer, row-major. Optional macro WRITEBACK_SKIP_BG_EN drops BG_KEY pixels.
module tile_writeback #(
    parameter int          DIM      = 8,
    parameter int          SCREEN_W = 640,
    parameter int          SCREEN_H = 480,
    parameter int          ADDR_W   = 20,
    parameter logic [15:0] BG_KEY   = 16'h0000
) (
    input  logic        BOARD_CLK,
    input  logic        BOARD_RESET_N,
    input  logic [15:0] nanoTile0 [DIM][DIM],
    input  logic [15:0] nanoTile1 [DIM][DIM],
    input  logic        readTileID,
    input  logic [9:0]  tileOffsetX,
    input  logic [9:0]  tileOffsetY,
    input  logic        startWriteback,
    tile_writeback_if.master pix,
    output logic        doneWriteback
);
    localparam int PX_W = $clog2(DIM);
    localparam logic [PX_W-1:0] PX_MAX = PX_W'(DIM - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STREAM, ST_DONE} state_t;

    state_t            r_state, w_state_next;
    logic [PX_W-1:0]   r_px, r_py, w_px_next, w_py_next;
    logic              r_tile_id;
    logic [9:0]        r_tile_x, r_tile_y;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;

    logic              w_adv, w_last, w_load, w_clip, w_skip;
    logic [10:0]       w_sx, w_sy;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       w_pix_data;
    logic [15:0]       w_tile [DIM][DIM];

    genvar gi, gj;
    generate
        for (gi = 0; gi < DIM; gi++) begin : g_col
            for (gj = 0; gj < DIM; gj++) begin : g_row
                assign w_tile[gi][gj] = r_tile_id ? nanoTile1[gi][gj] : nanoTile0[gi][gj];
            end
        end
    endgenerate

    // The pixel currently held in the output register retires when its beat is
    // taken, or after its single silent cycle when it produced no beat.
    assign w_adv  = (r_state == ST_STREAM) && (!r_valid || pix.pixReady);
    assign w_last = (r_px == PX_MAX) && (r_py == PX_MAX);

    always_ff @(posedge BOARD_CLK) begin
        if (!BOARD_RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_px_next    = r_px;
        w_py_next    = r_py;
        w_load       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (startWriteback) begin
                    w_state_next = ST_SETUP;
                    w_px_next    = '0;
                    w_py_next    = '0;
                end
            end
            ST_SETUP: begin
                w_state_next = ST_STREAM;
                w_load       = 1'b1;
            end
            ST_STREAM: begin
                if (w_adv) begin
                    if (w_last) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_load = 1'b1;
                        if (r_px == PX_MAX) begin
                            w_px_next = '0;
                            w_py_next = r_py + 1'b1;
                        end else begin
                            w_px_next = r_px + 1'b1;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!startWriteback) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Evaluate the pixel about to enter the output register.
    assign w_sx       = {1'b0, r_tile_x} + {{(11 - PX_W){1'b0}}, w_px_next};
    assign w_sy       = {1'b0, r_tile_y} + {{(11 - PX_W){1'b0}}, w_py_next};
    assign w_clip     = (w_sx >= 11'(SCREEN_W)) || (w_sy >= 11'(SCREEN_H));
    assign w_addr     = ADDR_W'(w_sy) * ADDR_W'(SCREEN_W) + ADDR_W'(w_sx);
    assign w_pix_data = w_tile[w_px_next][w_py_next];

`ifdef WRITEBACK_SKIP_BG_EN
    assign w_skip = w_clip || (w_pix_data == BG_KEY);
`else
    assign w_skip = w_clip;
`endif

    always_ff @(posedge BOARD_CLK) begin
        if (!BOARD_RESET_N) begin
            r_px      <= '0;
            r_py      <= '0;
            r_tile_id <= 1'b0;
            r_tile_x  <= '0;
            r_tile_y  <= '0;
            r_valid   <= 1'b0;
            r_addr    <= '0;
            r_data    <= '0;
        end else begin
            r_px <= w_px_next;
            r_py <= w_py_next;
            if (r_state == ST_IDLE && startWriteback) begin
                r_tile_id <= readTileID;
                r_tile_x  <= tileOffsetX;
                r_tile_y  <= tileOffsetY;
            end
            if (w_load) begin
                r_valid <= !w_skip;
                if (!w_skip) begin
                    r_addr <= w_addr;
                    r_data <= w_pix_data;
                end
            end else if (w_adv) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign pix.pixValid  = r_valid;
    assign pix.pixAddr   = r_addr;
    assign pix.pixData   = r_data;
    assign doneWriteback = (r_state == ST_IDLE) || (r_state == ST_DONE);
endmodule

// File: tb/tb_tile_writeback.sv
// Bench for tile_writeback: directed and randomized tiles checked against a
// row-major reference list of expected beats and cycle-level timing.
module tb_tile_writeback;
    localparam int DIM = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] t0 [DIM][DIM];
    logic [15:0] t1 [DIM][DIM];
    logic        tile_id = 1'b0;
    logic [9:0]  ox = '0, oy = '0;
    logic        start = 1'b0;
    logic        done;

    tile_writeback_if #(.ADDR_W(20)) pix_if ();

    tile_writeback #(.DIM(DIM), .SCREEN_W(640), .SCREEN_H(480), .ADDR_W(20), .BG_KEY(16'h0000)) dut (
        .BOARD_CLK      (clk),
        .BOARD_RESET_N  (rst_n),
        .nanoTile0      (t0),
        .nanoTile1      (t1),
        .readTileID     (tile_id),
        .tileOffsetX    (ox),
        .tileOffsetY    (oy),
        .startWriteback (start),
        .pix            (pix_if),
        .doneWriteback  (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    int q_addr[$];
    int q_data[$];
    int q_slot[$];
    int g_addr[$];
    int g_data[$];

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference: walk the tile row-major, keep pixels that land on screen.
    task automatic build_model();
        int sx, sy, d;
        q_addr.delete(); q_data.delete(); q_slot.delete();
        for (int py = 0; py < DIM; py++) begin
            for (int px = 0; px < DIM; px++) begin
                sx = int'(ox) + px;
                sy = int'(oy) + py;
                d  = tile_id ? int'(t1[px][py]) : int'(t0[px][py]);
                if (sx >= 640 || sy >= 480) continue;
`ifdef WRITEBACK_SKIP_BG_EN
                if (d == 0) continue;
`endif
                q_addr.push_back((sy * 640 + sx) & 32'hFFFFF);
                q_data.push_back(d);
                q_slot.push_back(py * DIM + px);
            end
        end
    endtask

    // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready.
    // abort_after > 0 stops after that many beats, leaving the stream running.
    task automatic run_tile(input string name, input int mode, input int abort_after);
        int c, n, first_v, last_b, done_c;
        bit hold;
        int h_addr, h_data;
        build_model();
        g_addr.delete(); g_data.delete();
        n = 0; first_v = -1; last_b = -1; done_c = -1; hold = 0; h_addr = 0; h_data = 0;
        @(negedge clk);
        start = 1'b1;
        pix_if.pixReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        chk({name, " done drops"}, int'(done), 0);
        while (c < 2000) begin
            case (mode)
                0: pix_if.pixReady = 1'b1;
                1: pix_if.pixReady = (c % 3 == 2);
                default: pix_if.pixReady = 1'($urandom_range(0, 1));
            endcase
            if (c >= 2 && done) begin
                done_c = c;
                break;
            end
            if (hold) begin
                chk({name, " hold valid"}, int'(pix_if.pixValid), 1);
                chk({name, " hold addr"}, int'(pix_if.pixAddr), h_addr);
                chk({name, " hold data"}, int'(pix_if.pixData), h_data);
            end
            if (pix_if.pixValid && first_v < 0) first_v = c;
            if (pix_if.pixValid && pix_if.pixReady) begin
                g_addr.push_back(int'(pix_if.pixAddr));
                g_data.push_back(int'(pix_if.pixData));
                if (n < q_addr.size()) begin
                    chk($sformatf("%s beat%0d addr", name, n), int'(pix_if.pixAddr), q_addr[n]);
                    chk($sformatf("%s beat%0d data", name, n), int'(pix_if.pixData), q_data[n]);
                end else begin
                    chk($sformatf("%s extra beat%0d", name, n), n, q_addr.size() - 1);
                end
                n++;
                last_b = c;
                if (abort_after > 0 && n == abort_after) break;
            end
            hold   = pix_if.pixValid && !pix_if.pixReady;
            h_addr = int'(pix_if.pixAddr);
            h_data = int'(pix_if.pixData);
            @(negedge clk);
            c++;
        end
        if (abort_after > 0) begin
            chk({name, " beats before abort"}, n, abort_after);
        end else begin
            chk({name, " finished in budget"}, int'(done_c > 0), 1);
            chk({name, " beat count"}, n, q_addr.size());
            if (mode == 0) begin
                chk({name, " done cycle"}, done_c, DIM * DIM + 2);
                if (q_slot.size() > 0) begin
                    chk({name, " first valid cycle"}, first_v, q_slot[0] + 2);
                    chk({name, " last beat cycle"}, last_b, q_slot[q_slot.size() - 1] + 2);
                end
            end
            $display("run %s mode=%0d id=%0d off=(%0d,%0d) beats=%0d done_cycle=%0d",
                     name, mode, tile_id, ox, oy, n, done_c);
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    task automatic fill_pattern();
        for (int x = 0; x < DIM; x++)
            for (int y = 0; y < DIM; y++) begin
                t0[x][y] = {5'(y), 6'(x), 5'b0};
                t1[x][y] = 16'hF81F;
            end
    endtask

    initial begin
        pix_if.pixReady = 1'b1;
        fill_pattern();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset valid", int'(pix_if.pixValid), 0);
        chk("reset addr", int'(pix_if.pixAddr), 0);
        chk("reset data", int'(pix_if.pixData), 0);
        chk("reset done", int'(done), 1);

        // Test pattern tile0 at (16,8)
        tile_id = 1'b0; ox = 10'd16; oy = 10'd8;
        run_tile("pattern", 0, 0);
        if (g_addr.size() > 9) begin
            chk("pattern beat0 addr const", g_addr[0], 5136);
            chk("pattern beat9 addr const", g_addr[9], 5777);
            chk("pattern beat9 data const", g_data[9], 16'h0820);
        end

        // Buffer 1, solid magenta
        tile_id = 1'b1;
        run_tile("tile1", 0, 0);
        if (g_data.size() > 63) chk("tile1 beat63 data const", g_data[63], 16'hF81F);

        // Bottom-right corner clipping
        tile_id = 1'b0; ox = 10'd636; oy = 10'd476;
        run_tile("clip", 0, 0);
        chk("clip beat count const", g_addr.size(), 16);
        if (g_addr.size() > 0) chk("clip last addr const", g_addr[g_addr.size() - 1], 307199);

        // Back-pressure
        ox = 10'd16; oy = 10'd8;
        run_tile("toggle", 1, 0);

        // Reset in mid-stream after beat 20
        run_tile("abort", 0, 21);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort valid", int'(pix_if.pixValid), 0);
        chk("abort done", int'(done), 1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-abort valid", int'(pix_if.pixValid), 0);
        run_tile("restart", 0, 0);
        if (g_addr.size() > 0) chk("restart beat0 addr const", g_addr[0], 5136);

        // Background tile with a single green pixel
        for (int x = 0; x < DIM; x++)
            for (int y = 0; y < DIM; y++) t0[x][y] = 16'h0000;
        t0[3][2] = 16'h07E0;
        ox = 10'd0; oy = 10'd0;
        run_tile("bgkey", 0, 0);
`ifdef WRITEBACK_SKIP_BG_EN
        chk("bgkey beat count", g_addr.size(), 1);
        if (g_addr.size() > 0) chk("bgkey addr const", g_addr[0], 1283);
`else
        chk("bgkey beat count", g_addr.size(), 64);
        if (g_addr.size() > 19) chk("bgkey beat19 data const", g_data[19], 16'h07E0);
`endif

        // Randomized tiles, offsets and back-pressure
        for (int r = 0; r < 6; r++) begin
            for (int x = 0; x < DIM; x++)
                for (int y = 0; y < DIM; y++) begin
                    t0[x][y] = 16'($urandom);
                    t1[x][y] = 16'($urandom);
                end
            tile_id = 1'($urandom_range(0, 1));
            ox = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(628, 645)) : 10'($urandom_range(0, 632));
            oy = ($urandom_range(0, 1) == 1) ? 10'($urandom_range(468, 485)) : 10'($urandom_range(0, 472));
            run_tile($sformatf("rand%0d", r), (r % 2 == 0) ? 2 : 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
